// File: rtl/inst_sequencer.sv
// inst_sequencer: fetch/load/execute/wait controller that streams 32-bit
// instructions from a synchronous program memory into the datapath IR.
// Optional feature macro: SINGLE_STEP_EN adds a `step` input. When `step` is
// low, the sequencer parks in NEXT after each instruction.
module inst_sequencer #(
    parameter int PC_W         = 16,
    parameter int DELAY_CYCLES = 4,
    parameter int HALT_OP      = 31
) (
    input  logic            clk,
    input  logic            sys_rst,
    input  logic            start,
`ifdef SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic [PC_W-1:0] pmem_addr,
    input  logic [31:0]     pmem_rdata,
    output logic [31:0]     ir,
    output logic            exec_en,
    input  logic            exec_done,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_addr,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, EXEC, WAIT, NEXT, HALT} state_t;

    // A zero or one-cycle delay both collapse to a single NEXT cycle.
    localparam int CNT_W = DELAY_CYCLES > 1 ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = DELAY_CYCLES > 0 ? CNT_W'(DELAY_CYCLES - 1) : '0;

    state_t           state, state_nx;
    logic [PC_W-1:0]  pc_nx;
    logic [31:0]      ir_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             delay_done;
    logic             go;

    assign delay_done = cnt == CNT_LAST;
`ifdef SINGLE_STEP_EN
    assign go = delay_done & step;
`else
    assign go = delay_done;
`endif

    assign pmem_addr = pc;
    assign exec_en   = state == EXEC;
    assign busy      = state != IDLE && state != HALT;
    assign halted    = state == HALT;

    // Next-state and register updates; everything holds unless a state moves it.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ir_nx    = ir;
        cnt_nx   = cnt;
        case (state)
            IDLE:  state_nx = start ? FETCH : IDLE;
            FETCH: state_nx = LOAD;
            LOAD: begin
                ir_nx    = pmem_rdata;
                state_nx = pmem_rdata[31:27] == 5'(HALT_OP) ? HALT : EXEC;
            end
            EXEC:  state_nx = WAIT;
            WAIT: begin
                if (exec_done) begin
                    pc_nx    = jump_en ? jump_addr : pc + PC_W'(1);
                    state_nx = NEXT;
                end
            end
            NEXT: begin
                cnt_nx   = go ? '0 : (delay_done ? cnt : cnt + CNT_W'(1));
                state_nx = go ? FETCH : NEXT;
            end
            HALT:    state_nx = start ? FETCH : HALT;
            default: state_nx = IDLE;
        endcase
    end

    // State and datapath registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            ir    <= ir_nx;
            cnt   <= cnt_nx;
        end
    end

endmodule
